// File: rtl/frequency_meter.sv
// Gated frequency meter: counts synchronized rising edges of meas_in over a
// selectable gate of GATE_1S / {1,10,100,1000} clk cycles, single-shot or continuous.
module frequency_meter #(
    parameter int GATE_1S = 50_000_000,
    parameter int COUNT_W = 27
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               meas_in,
    input  logic               start,
    input  logic               cont,
    input  logic [1:0]         gate_sel,
    output logic [COUNT_W-1:0] freq_count,
    output logic               valid,
    output logic               overflow,
    output logic               busy
);

    localparam int GATE_W  = $clog2(GATE_1S + 1);
    localparam int N3_RAW  = GATE_1S / 1000;
    localparam int N3_INT  = (N3_RAW == 0) ? 1 : N3_RAW;

    localparam logic [GATE_W-1:0]  N_SEL0    = GATE_W'(GATE_1S);
    localparam logic [GATE_W-1:0]  N_SEL1    = GATE_W'(GATE_1S / 10);
    localparam logic [GATE_W-1:0]  N_SEL2    = GATE_W'(GATE_1S / 100);
    localparam logic [GATE_W-1:0]  N_SEL3    = GATE_W'(N3_INT);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               meas_s1;
    logic               meas_s2;
    logic               meas_prev;
    logic               edge_p;
    logic [GATE_W-1:0]  gate_cnt;
    logic [GATE_W-1:0]  gate_len;
    logic [COUNT_W-1:0] edge_cnt;
    logic [COUNT_W-1:0] edge_cnt_next;
    logic               sat;
    logic               sat_next;
    logic               gate_last;

    always_comb begin
        case (gate_sel)
            2'b00:   gate_len = N_SEL0;
            2'b01:   gate_len = N_SEL1;
            2'b10:   gate_len = N_SEL2;
            default: gate_len = N_SEL3;
        endcase
    end

    assign gate_last = (gate_cnt == GATE_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start || cont) state_next = ARM;
            ARM:     state_next = GATE;
            GATE:    if (gate_last) state_next = DONE;
            DONE:    state_next = cont ? ARM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Saturating edge counter; the count including the final gate cycle is
    // published on entry to DONE so freq_count is already valid with the pulse.
    always_comb begin
        edge_cnt_next = edge_cnt;
        sat_next      = sat;
        if (state == GATE && edge_p) begin
            if (edge_cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            meas_s1    <= 1'b0;
            meas_s2    <= 1'b0;
            meas_prev  <= 1'b0;
            edge_p     <= 1'b0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state     <= state_next;
            meas_s1   <= meas_in;
            meas_s2   <= meas_s1;
            meas_prev <= meas_s2;
            edge_p    <= meas_s2 & ~meas_prev;
            case (state)
                ARM: begin
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    gate_cnt <= gate_len;
                end
                GATE: begin
                    gate_cnt <= gate_cnt - GATE_LAST;
                    edge_cnt <= edge_cnt_next;
                    sat      <= sat_next;
                    if (gate_last) begin
                        freq_count <= edge_cnt_next;
                        overflow   <= sat_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state == ARM) || (state == GATE);

endmodule
